// File: rtl/mem_access_pkg.sv
// Shared definitions for the mem_access stage: access-size encodings,
// FSM state encodings, default datapath width and the byte-strobe helper.
package mem_access_pkg;

  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  // Byte strobe for an access of the given size, anchored at lane 0.
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_B:    return 8'h01;
      SZ_H:    return 8'h03;
      SZ_W:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic for mem_access: store shift and strobe, load
// extraction with sign/zero extension, and the misalignment flag.
module mem_align
  import mem_access_pkg::*;
#(
  parameter int DATA_W = XLEN
) (
  input  logic [2:0]        offset,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  input  logic [DATA_W-1:0] st_wdata,
  input  logic [DATA_W-1:0] ld_rdata,
  output logic [DATA_W-1:0] st_data,
  output logic [7:0]        st_mask,
  output logic [DATA_W-1:0] ld_data,
  output logic              misalign
);

  logic [5:0]        bit_shift;
  logic [DATA_W-1:0] ld_shifted;
  logic signed [7:0]  ld_b;
  logic signed [15:0] ld_h;
  logic signed [31:0] ld_w;

  assign bit_shift  = {offset, 3'b000};
  assign st_data    = st_wdata << bit_shift;
  assign st_mask    = size_mask(size) << offset;
  assign ld_shifted = ld_rdata >> bit_shift;
  assign ld_b       = ld_shifted[7:0];
  assign ld_h       = ld_shifted[15:0];
  assign ld_w       = ld_shifted[31:0];

  // Pick the load width, extend it, and flag offsets not multiple of size
  always_comb begin
    ld_data  = ld_shifted;
    misalign = 1'b0;
    case (size)
      SZ_B: begin
        ld_data = is_unsigned ? DATA_W'(ld_shifted[7:0]) : DATA_W'(ld_b);
      end
      SZ_H: begin
        ld_data  = is_unsigned ? DATA_W'(ld_shifted[15:0]) : DATA_W'(ld_h);
        misalign = offset[0];
      end
      SZ_W: begin
        ld_data  = is_unsigned ? DATA_W'(ld_shifted[31:0]) : DATA_W'(ld_w);
        misalign = |offset[1:0];
      end
      default: begin
        ld_data  = ld_shifted;
        misalign = |offset;
      end
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage between ex_mem and mem_wb. Issues loads/stores over a
// req/gnt/rvalid port, stalls upstream while a transaction is outstanding,
// and registers the writeback slot. Optional feature macro:
// MEM_STORE_COMMIT_EN adds a store-commit pulse for difftest comparison.
module mem_access #(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic [XLEN-1:0] inst_addr_i,
  input  logic [4:0]      reg_waddr_i,
  input  logic [XLEN-1:0] reg_wdata_i,
  input  logic            reg_wen_i,
  input  logic            mem_ren_i,
  input  logic            mem_wen_i,
  input  logic [1:0]      mem_size_i,
  input  logic            mem_unsigned_i,
  input  logic [XLEN-1:0] mem_addr_i,
  input  logic [XLEN-1:0] mem_wdata_i,
  output logic            stall_o,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  output logic [7:0]      dmem_wmask_o,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic            valid_o,
  output logic [XLEN-1:0] inst_addr_o,
  output logic [4:0]      reg_waddr_o,
  output logic [XLEN-1:0] reg_wdata_o,
  output logic            reg_wen_o,
  output logic            misalign_o,
  output logic            bus_err_o
`ifdef MEM_STORE_COMMIT_EN
  ,
  output logic            st_commit_o,
  output logic [XLEN-1:0] st_addr_o,
  output logic [XLEN-1:0] st_data_o,
  output logic [7:0]      st_mask_o
`endif
);

  import mem_access_pkg::*;

  state_e state, state_d;
  logic [7:0] cnt;

  // Instruction fields captured when a memory op is accepted
  logic [XLEN-1:0] pc_p0, alu_p0, addr_p0, st_data_p0;
  logic [4:0]      waddr_p0;
  logic [1:0]      size_p0;
  logic [7:0]      mask_p0;
  logic            wen_p0, load_p0, uns_p0;

  logic            mem_op, accept, finish, err, timeout;
  logic [2:0]      al_off;
  logic [1:0]      al_size;
  logic            al_uns, al_mis;
  logic [XLEN-1:0] al_st_data, al_ld_data;
  logic [7:0]      al_st_mask;

  assign mem_op  = mem_ren_i | mem_wen_i;
  assign accept  = (state == IDLE) && valid_i && mem_op && !al_mis;
  assign timeout = (cnt == 8'(TIMEOUT - 1));

  // The aligner looks at the incoming op in IDLE and the latched op otherwise
  assign al_off  = (state == IDLE) ? mem_addr_i[2:0] : addr_p0[2:0];
  assign al_size = (state == IDLE) ? mem_size_i : size_p0;
  assign al_uns  = (state == IDLE) ? mem_unsigned_i : uns_p0;

  mem_align #(.DATA_W(XLEN)) u_align (
    .offset      (al_off),
    .size        (al_size),
    .is_unsigned (al_uns),
    .st_wdata    (mem_wdata_i),
    .ld_rdata    (dmem_rdata_i),
    .st_data     (al_st_data),
    .st_mask     (al_st_mask),
    .ld_data     (al_ld_data),
    .misalign    (al_mis)
  );

  assign dmem_we_o    = dmem_req_o & ~load_p0;
  assign dmem_addr_o  = dmem_req_o ? {addr_p0[XLEN-1:3], 3'b000} : '0;
  assign dmem_wdata_o = dmem_req_o ? st_data_p0 : '0;
  assign dmem_wmask_o = dmem_req_o ? mask_p0 : 8'h00;

  // Next-state, handshake and stall decode
  always_comb begin
    state_d    = state;
    stall_o    = 1'b0;
    dmem_req_o = 1'b0;
    finish     = 1'b0;
    err        = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_d = REQ;
          stall_o = 1'b1;
        end
      end
      REQ: begin
        dmem_req_o = 1'b1;
        stall_o    = 1'b1;
        if (dmem_gnt_i) begin
          // A load whose data arrives with the grant skips WAIT
          if (!load_p0 || dmem_rvalid_i) begin
            state_d = RESP;
            finish  = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end else if (timeout) begin
          state_d = RESP;
          finish  = 1'b1;
          err     = 1'b1;
        end
      end
      WAIT: begin
        stall_o = 1'b1;
        if (dmem_rvalid_i) begin
          state_d = RESP;
          finish  = 1'b1;
        end else if (timeout) begin
          state_d = RESP;
          finish  = 1'b1;
          err     = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register and handshake timeout counter (cleared on state entry)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_d;
      if (state_d != state) begin
        cnt <= 8'd0;
      end else if (state == REQ || state == WAIT) begin
        cnt <= cnt + 8'd1;
      end else begin
        cnt <= 8'd0;
      end
    end
  end

  // Capture the accepted memory op; data only, so no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      pc_p0      <= inst_addr_i;
      alu_p0     <= reg_wdata_i;
      addr_p0    <= mem_addr_i;
      waddr_p0   <= reg_waddr_i;
      wen_p0     <= reg_wen_i;
      load_p0    <= !mem_wen_i;
      size_p0    <= mem_size_i;
      uns_p0     <= mem_unsigned_i;
      st_data_p0 <= al_st_data;
      mask_p0    <= al_st_mask;
    end
  end

  // Writeback slot to mem_wb: passthrough/misalign from IDLE, else on finish
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_o     <= 1'b0;
      inst_addr_o <= '0;
      reg_waddr_o <= '0;
      reg_wdata_o <= '0;
      reg_wen_o   <= 1'b0;
      misalign_o  <= 1'b0;
      bus_err_o   <= 1'b0;
`ifdef MEM_STORE_COMMIT_EN
      st_commit_o <= 1'b0;
      st_addr_o   <= '0;
      st_data_o   <= '0;
      st_mask_o   <= 8'h00;
`endif
    end else begin
      valid_o    <= 1'b0;
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
`ifdef MEM_STORE_COMMIT_EN
      st_commit_o <= 1'b0;
`endif
      if (state == IDLE && valid_i && !accept) begin
        valid_o     <= 1'b1;
        inst_addr_o <= inst_addr_i;
        reg_waddr_o <= reg_waddr_i;
        reg_wdata_o <= reg_wdata_i;
        reg_wen_o   <= mem_op ? 1'b0 : reg_wen_i;
        misalign_o  <= mem_op;
      end else if (finish) begin
        valid_o     <= 1'b1;
        inst_addr_o <= pc_p0;
        reg_waddr_o <= waddr_p0;
        reg_wdata_o <= (load_p0 && !err) ? al_ld_data : alu_p0;
        reg_wen_o   <= load_p0 && !err && wen_p0 && (waddr_p0 != 5'd0);
        bus_err_o   <= err;
`ifdef MEM_STORE_COMMIT_EN
        st_commit_o <= !load_p0 && !err;
        st_addr_o   <= addr_p0;
        st_data_o   <= st_data_p0;
        st_mask_o   <= mask_p0;
`endif
      end
    end
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-access pipeline stage between the ex_mem register and the mem_wb register; its outputs are registered and feed mem_wb directly.
- Issues load/store requests to the data-memory port with a req/gnt/rvalid handshake.
- Aligns store data and byte masks, and extracts and sign/zero-extends load data.
- Stalls upstream while a memory transaction is outstanding; non-memory instructions pass through with one-cycle latency.

Parameters:
- XLEN, 64, datapath and address width
- TIMEOUT, 255, maximum cycles waiting for gnt or rvalid before a bus error is flagged (8-bit counter)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- valid_i  in  1  ex_mem slot holds an instruction
- inst_addr_i  in  64  instruction PC
- reg_waddr_i  in  5  destination register
- reg_wdata_i  in  64  ALU result (used for non-load writeback)
- reg_wen_i  in  1  register write enable
- mem_ren_i  in  1  load
- mem_wen_i  in  1  store
- mem_size_i  in  2  0=byte, 1=half, 2=word, 3=double
- mem_unsigned_i  in  1  zero-extend load
- mem_addr_i  in  64  byte address
- mem_wdata_i  in  64  store data, LSB-justified
- stall_o  out  1  hold ex_mem contents
- dmem_req_o  out  1  request valid
- dmem_we_o  out  1  write request
- dmem_addr_o  out  64  address, 8-byte aligned ({addr[63:3],3'b0})
- dmem_wdata_o  out  64  store data shifted to byte lane
- dmem_wmask_o  out  8  byte-lane strobe
- dmem_gnt_i  in  1  request accepted
- dmem_rvalid_i  in  1  read data valid
- dmem_rdata_i  in  64  read data (aligned doubleword)
- valid_o  out  1  to mem_wb: slot valid
- inst_addr_o  out  64  PC
- reg_waddr_o  out  5  destination register
- reg_wdata_o  out  64  writeback data
- reg_wen_o  out  1  writeback enable
- misalign_o  out  1  address misaligned for the access size
- bus_err_o  out  1  handshake timeout

Behaviour:
- Reset: all outputs 0, FSM in IDLE, timeout counter 0.
- Reset mid-transaction: the transaction is abandoned and dmem_req_o drops immediately. No writeback is produced for it.
- FSM states: IDLE, REQ, WAIT, and RESP.
- IDLE, valid_i=0: valid_o=0 next cycle.
- IDLE, valid_i=1, no memory op: all fields registered to the outputs next cycle with valid_o=1 (latency 1).
- IDLE, valid_i=1, memory op, aligned: latch all inputs and go to REQ. stall_o is asserted combinationally in the same cycle.
- Misalignment test: addr[0] set for half, addr[1:0]≠0 for word, addr[2:0]≠0 for double.
- IDLE, valid_i=1, memory op, misaligned: no request is issued. Next cycle: valid_o=1, reg_wen_o=0, misalign_o=1.
- REQ: dmem_req_o=1, held stable until dmem_gnt_i.
  - Store and gnt: go to RESP.
  - Load and gnt: go to WAIT.
- WAIT: on dmem_rvalid_i, capture the extracted data and go to RESP.
- Load extraction: byte lane = addr[2:0], size selects the width, mem_unsigned_i selects zero- vs sign-extension.
- Store lanes: dmem_wdata_o = mem_wdata_i << (8*addr[2:0]). dmem_wmask_o = 8'h01/03/0F/FF << addr[2:0].
- RESP: outputs valid_o=1 for exactly one cycle and returns to IDLE.
  - Load: reg_wdata_o = extracted data, reg_wen_o = reg_wen_i & (reg_waddr≠0).
  - Store: reg_wen_o=0.
- stall_o is high in REQ and WAIT, and in the IDLE acceptance cycle of a memory op. It is low in RESP, so the next instruction is presented in the RESP cycle and accepted in the following cycle.
- Timeout: the counter increments each cycle in REQ/WAIT and clears on state entry. On reaching TIMEOUT, go to RESP with bus_err_o=1 and reg_wen_o=0.
- gnt and rvalid asserted in the same cycle: the load goes straight from REQ to RESP using dmem_rdata_i.
- rvalid seen outside WAIT is ignored.
- misalign_o and bus_err_o are valid only with valid_o=1; otherwise 0.

Optional Feature:
- Macro: MEM_STORE_COMMIT_EN.
- Defined: adds outputs st_commit_o(1), st_addr_o(64), st_data_o(64) and st_mask_o(8), pulsed in the RESP cycle of a successful store for difftest comparison.
- Undefined: these ports and their registers are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package (defines header): size encodings SZ_B/H/W/D, FSM state encodings, XLEN.
- One natural sub-module: mem_align, purely combinational. It produces store shift/mask, load extract/extend, and the misalign flag.

Test Plan:
- ADD passthrough: valid_i=1, reg_waddr=5, wdata=0x1234 -> next cycle valid_o=1, reg_wdata_o=0x1234, reg_wen_o=1, stall_o never asserted.
- LB signed: addr=0x8000_0003, rdata=0x0000_0000_8000_0000 (byte 3=0x80), gnt after 2 cycles, rvalid after 3 more -> reg_wdata_o=0xFFFF_FFFF_FFFF_FF80, one valid_o pulse.
- SH: addr=0x...6, wdata=0xBEEF -> dmem_wmask_o=8'hC0, dmem_wdata_o=0xBEEF_0000_0000_0000, dmem_addr_o=0x...0, reg_wen_o=0.
- Misaligned LW at addr=0x...2 -> dmem_req_o stays 0, next cycle valid_o=1, misalign_o=1, reg_wen_o=0.
- Timeout: gnt never asserted -> after 255 cycles in REQ, valid_o=1, bus_err_o=1, then back to IDLE.
- Assert rst while in WAIT -> dmem_req_o=0, valid_o=0, FSM in IDLE; a subsequent LD completes normally.
